mux_scan_ctrl: RTL and testbench

Sequential scan controller that sits directly in front of the 16:1 bit multiplexer (`sixtoone`, ports `a[15:0]`, `s[3:0]`, `f`). On a start request it presents a latched 16-bit word to the mux and steps the mux select through 0..15. For each select value it samples the mux output `f` and rebuilds the word bit by bit, producing the reassembled word plus a population count. This gives a self-checking serial read-out path and the select-sequencing stage the mux needs in the lab top level.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/scan_step_timer.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 104 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: FSM encoding and default widths.
package mux_scan_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;
  localparam int ONES_W    = DEF_SEL_W + 1;

  typedef logic [ONES_W-1:0] ones_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/scan_step_timer.sv
// Hold-window counter: strobes step on the last cycle of every HOLD-cycle window.
module scan_step_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic step
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt;

  assign step = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 mux select through every input and rebuilds the presented word
// from the sampled mux output, with a population count of the sampled bits.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] mux_a,
  output logic [SEL_W-1:0] mux_s,
  input  logic             mux_f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [SEL_W:0]   ones_cnt
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [SEL_W:0]   shadow_cnt;
  logic [SEL_W:0]   shadow_cnt_nxt;
  logic             accept;
  logic             step;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = step && (mux_s == LAST_SEL);

  scan_step_timer #(.HOLD(HOLD)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == SCAN),
    .step  (step)
  );

  // The final sample must reach data_out on the same edge it is taken.
  always_comb begin
    shadow_nxt        = shadow;
    shadow_nxt[mux_s] = mux_f;
    shadow_cnt_nxt    = shadow_cnt + (SEL_W+1)'(mux_f);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mux_a      <= '0;
      mux_s      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      ones_cnt   <= '0;
      shadow     <= '0;
      shadow_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SCAN;
            mux_a      <= data_in;
            mux_s      <= '0;
            shadow     <= '0;
            shadow_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (step) begin
            shadow     <= shadow_nxt;
            shadow_cnt <= shadow_cnt_nxt;
            if (last) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              data_out <= shadow_nxt;
              ones_cnt <= shadow_cnt_nxt;
            end else begin
              mux_s <= mux_s + SEL_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two controllers (HOLD=1 and HOLD=3) each driving a 16:1 mux model.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start3 = 1'b0;
  logic [15:0] data1 = '0, data3 = '0;
  logic [15:0] mux_a1, mux_a3, data_out1, data_out3;
  logic [3:0]  mux_s1, mux_s3;
  logic        mux_f1, mux_f3, busy1, busy3, done1, done3;
  logic [4:0]  ones1, ones3;

  // sixtoone behaviour: f = a[s]
  assign mux_f1 = mux_a1[mux_s1];
  assign mux_f3 = mux_a3[mux_s3];

  mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .mux_a(mux_a1), .mux_s(mux_s1), .mux_f(mux_f1),
    .busy(busy1), .done(done1), .data_out(data_out1), .ones_cnt(ones1)
  );

  mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .data_in(data3),
    .mux_a(mux_a3), .mux_s(mux_s3), .mux_f(mux_f3),
    .busy(busy3), .done(done3), .data_out(data_out3), .ones_cnt(ones3)
  );

  typedef struct {
    logic [15:0] d;
    ones_t       c;
    int          cy;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("data_out1", data_out1, e.d);
        chk("ones_cnt1", ones1, e.c);
        chk("done_cycle1", cyc, e.cy);
        chk("busy_low_at_done1", busy1, 0);
      end
    end
    if (done3) begin
      if (q3.size() == 0) chk("unexpected_done3", 1, 0);
      else begin
        e = q3.pop_front();
        chk("data_out3", data_out3, e.d);
        chk("ones_cnt3", ones3, e.c);
        chk("done_cycle3", cyc, e.cy);
      end
    end
  end

  // Requests a scan, waits for acceptance, then follows the select sequence
  // until the cycle where done is due. pulse_at >= 0 re-pulses start mid-scan.
  task automatic do_scan(input int inst, input logic [15:0] d, input logic [4:0] cnt,
                         input int pulse_at);
    int  h, e;
    bit  ok;
    h = (inst == 3) ? 3 : 1;
    if (inst == 3) begin data3 = d; start3 = 1'b1; end
    else           begin data1 = d; start1 = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = (inst == 3) ? busy3 : busy1;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    chk("start_accept", ok, 1);
    if (!ok) return;
    e = cyc;
    if (inst == 3) q3.push_back('{d, cnt, e + 16*h});
    else           q1.push_back('{d, cnt, e + 16*h});
    chk("mux_a_latch", (inst == 3) ? mux_a3 : mux_a1, d);
    for (int t = 0; t < 16*h; t++) begin
      chk("mux_s_step", (inst == 3) ? mux_s3 : mux_s1, t / h);
      start1 = (inst == 1 && t == pulse_at);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mux_a", mux_a1, 0);
    chk("rst_mux_s", mux_s1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_data_out", data_out1, 0);
    chk("rst_ones_cnt", ones1, 0);
    chk("rst_busy3", busy3, 0);

    do_scan(1, 16'hAAAA, 5'd8, -1);
    do_scan(1, 16'h0000, 5'd0, -1);
    do_scan(1, 16'hFFFF, 5'd16, -1);
    do_scan(3, 16'h1234, 5'd5, -1);
    repeat (2) @(negedge clk);
    do_scan(1, 16'h00FF, 5'd8, 7);
    repeat (20) @(negedge clk);
    chk("prev_result_held", data_out1, 16'h00FF);

    // Reset in the middle of a scan discards everything.
    data1 = 16'hAAAA;
    start1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = busy1;
    end
    start1 = 1'b0;
    chk("rst_scan_accept", ok, 1);
    repeat (5) @(negedge clk);
    chk("pre_rst_sel", mux_s1, 5);
    chk("result_stable_in_scan", data_out1, 16'h00FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_mux_a", mux_a1, 0);
    chk("mid_rst_mux_s", mux_s1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_data_out", data_out1, 0);
    chk("mid_rst_ones_cnt", ones1, 0);
    repeat (25) @(negedge clk);
    chk("idle_after_rst", busy1, 0);
    chk("pending_q1", q1.size(), 0);
    chk("pending_q3", q3.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
